// File: rtl/dc_sched_pkg.sv
// Shared types for the data-cache tag-bank scheduler.
// Owner encoding, queue entry layout and bank-select bit.
package dc_sched_pkg;
  localparam int DC_ID_BITS = 4;
  localparam int BANK_SEL_BIT = 0;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_FILL = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e                owner;
    logic [DC_ID_BITS-1:0] id;
  } ownq_entry_t;
endpackage

// File: rtl/dc_sched_ownq.sv
// Per-bank owner queue: remembers who issued each
// in-flight lookup, in issue order.
module dc_sched_ownq
  import dc_sched_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int OW = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  ownq_entry_t   push_e,
  input  logic          pop,
  output ownq_entry_t   head,
  output logic [OW-1:0] occ,
  output logic          full,
  output logic          empty
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(QDEPTH - 1);
  localparam logic [OW-1:0] QD = OW'(QDEPTH);

  ownq_entry_t   mem [QDEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (occ == QD);
  assign empty   = (occ == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rp];

  // Entry storage; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= push_e;
  end

  // Pointers wrap at QDEPTH; occupancy tracks push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (do_push) wp <= (wp == LAST) ? '0 : wp + 1'b1;
      if (do_pop)  rp <= (rp == LAST) ? '0 : rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: rtl/dc_tagbank_sched.sv
// Arbitrates core and fill requesters onto even/odd tag
// banks and routes bank responses back to their owners.
module dc_tagbank_sched
  import dc_sched_pkg::*;
#(
  parameter int Width    = 24,
  parameter int REQ_BITS = 7,
  parameter int SET_BITS = 7,
  parameter int ID_BITS  = DC_ID_BITS,
  parameter int QDEPTH   = 2,
  parameter int OW       = $clog2(QDEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                c_req_valid,
  output logic                c_req_retry,
  input  logic [REQ_BITS-1:0] c_req_type,
  input  logic                c_req_write,
  input  logic [SET_BITS-1:0] c_req_set,
  input  logic [Width-1:0]    c_req_tag,
  input  logic [ID_BITS-1:0]  c_req_id,
  output logic                c_ack_valid,
  input  logic                c_ack_retry,
  output logic                c_ack_hit,
  output logic                c_ack_miss,
  output logic [2:0]          c_ack_way,
  output logic [ID_BITS-1:0]  c_ack_id,
  output logic                c_ack_bank,
  input  logic                f_req_valid,
  output logic                f_req_retry,
  input  logic [REQ_BITS-1:0] f_req_type,
  input  logic                f_req_write,
  input  logic [SET_BITS-1:0] f_req_set,
  input  logic [Width-1:0]    f_req_tag,
  input  logic [ID_BITS-1:0]  f_req_id,
  output logic                f_ack_valid,
  input  logic                f_ack_retry,
  output logic                f_ack_hit,
  output logic                f_ack_miss,
  output logic [2:0]          f_ack_way,
  output logic [ID_BITS-1:0]  f_ack_id,
  output logic                f_ack_bank,
  output logic                b0_req_valid,
  input  logic                b0_req_retry,
  output logic [REQ_BITS-1:0] b0_req_type,
  output logic                b0_req_write,
  output logic [Width-1:0]    b0_req_tag,
  output logic [SET_BITS-2:0] b0_req_set,
  input  logic                b0_ack_valid,
  output logic                b0_ack_retry,
  input  logic                b0_hit,
  input  logic                b0_miss,
  input  logic [2:0]          b0_way,
  output logic [OW-1:0]       b0_occ,
  output logic                b1_req_valid,
  input  logic                b1_req_retry,
  output logic [REQ_BITS-1:0] b1_req_type,
  output logic                b1_req_write,
  output logic [Width-1:0]    b1_req_tag,
  output logic [SET_BITS-2:0] b1_req_set,
  input  logic                b1_ack_valid,
  output logic                b1_ack_retry,
  input  logic                b1_hit,
  input  logic                b1_miss,
  input  logic [2:0]          b1_way,
  output logic [OW-1:0]       b1_occ,
  output logic                sched_err
);
  logic [1:0]    c_tgt, f_tgt;
  logic [1:0]    gnt_c, gnt_f, acc;
  logic [1:0]    full, empty;
  logic [1:0]    breq_retry, back_valid;
  logic [1:0]    route, pop, back_retry;
  ownq_entry_t   head [2];
  logic [OW-1:0] occ [2];
  logic          c_r0, c_r1, f_r0, f_r1, clash;
  logic          own0_rt, own1_rt;

  assign c_tgt[1] = c_req_valid & c_req_set[BANK_SEL_BIT];
  assign c_tgt[0] = c_req_valid & ~c_req_set[BANK_SEL_BIT];
  assign f_tgt[1] = f_req_valid & f_req_set[BANK_SEL_BIT];
  assign f_tgt[0] = f_req_valid & ~f_req_set[BANK_SEL_BIT];
  assign breq_retry = {b1_req_retry, b0_req_retry};
  assign back_valid = {b1_ack_valid, b0_ack_valid};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic        rr;
    ownq_entry_t push_e;

    assign gnt_c[b] = c_tgt[b] & ~full[b] & (~f_tgt[b] | ~rr);
    assign gnt_f[b] = f_tgt[b] & ~full[b] & (~c_tgt[b] | rr);
    assign acc[b]   = (gnt_c[b] | gnt_f[b]) & ~breq_retry[b];
    assign push_e   = gnt_c[b] ? '{OWN_CORE, c_req_id}
                               : '{OWN_FILL, f_req_id};

    // Round-robin turns over to the loser after a contended issue.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) rr <= 1'b0;
      else if (acc[b] & c_tgt[b] & f_tgt[b]) rr <= gnt_c[b];
    end

    dc_sched_ownq #(.QDEPTH(QDEPTH), .OW(OW)) u_q (
      .clk   (clk),
      .reset (reset),
      .push  (acc[b]),
      .push_e(push_e),
      .pop   (pop[b]),
      .head  (head[b]),
      .occ   (occ[b]),
      .full  (full[b]),
      .empty (empty[b])
    );
  end

  assign b0_req_valid = gnt_c[0] | gnt_f[0];
  assign b0_req_type  = gnt_f[0] ? f_req_type : c_req_type;
  assign b0_req_write = gnt_f[0] ? f_req_write : c_req_write;
  assign b0_req_tag   = gnt_f[0] ? f_req_tag : c_req_tag;
  assign b0_req_set   = gnt_f[0] ? f_req_set[SET_BITS-1:1]
                                 : c_req_set[SET_BITS-1:1];
  assign b1_req_valid = gnt_c[1] | gnt_f[1];
  assign b1_req_type  = gnt_f[1] ? f_req_type : c_req_type;
  assign b1_req_write = gnt_f[1] ? f_req_write : c_req_write;
  assign b1_req_tag   = gnt_f[1] ? f_req_tag : c_req_tag;
  assign b1_req_set   = gnt_f[1] ? f_req_set[SET_BITS-1:1]
                                 : c_req_set[SET_BITS-1:1];
  assign b0_occ = occ[0];
  assign b1_occ = occ[1];

  assign c_req_retry = c_req_valid & ~|(gnt_c & acc);
  assign f_req_retry = f_req_valid & ~|(gnt_f & acc);

  assign route = back_valid & ~empty;
  assign clash = route[0] & route[1] &
                 (head[0].owner == head[1].owner);
  assign c_r0  = route[0] & (head[0].owner == OWN_CORE);
  assign f_r0  = route[0] & (head[0].owner == OWN_FILL);
  assign c_r1  = route[1] & (head[1].owner == OWN_CORE) & ~c_r0;
  assign f_r1  = route[1] & (head[1].owner == OWN_FILL) & ~f_r0;

  assign own0_rt = (head[0].owner == OWN_CORE) ? c_ack_retry
                                               : f_ack_retry;
  assign own1_rt = (head[1].owner == OWN_CORE) ? c_ack_retry
                                               : f_ack_retry;
  assign back_retry[0] = route[0] & own0_rt;
  assign back_retry[1] = route[1] & (clash | own1_rt);
  assign b0_ack_retry  = back_retry[0];
  assign b1_ack_retry  = back_retry[1];
  assign pop = route & ~back_retry;

  assign c_ack_valid = c_r0 | c_r1;
  assign c_ack_bank  = ~c_r0;
  assign c_ack_hit   = c_r0 ? b0_hit : b1_hit;
  assign c_ack_miss  = c_r0 ? b0_miss : b1_miss;
  assign c_ack_way   = c_r0 ? b0_way : b1_way;
  assign c_ack_id    = c_r0 ? head[0].id : head[1].id;
  assign f_ack_valid = f_r0 | f_r1;
  assign f_ack_bank  = ~f_r0;
  assign f_ack_hit   = f_r0 ? b0_hit : b1_hit;
  assign f_ack_miss  = f_r0 ? b0_miss : b1_miss;
  assign f_ack_way   = f_r0 ? b0_way : b1_way;
  assign f_ack_id    = f_r0 ? head[0].id : head[1].id;

  // A bank response with no owner on record is a protocol error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sched_err <= 1'b0;
    else if (|(back_valid & empty)) sched_err <= 1'b1;
  end
endmodule

// File: tb/tb_dc_tagbank_sched.sv
// Directed bench for the tag-bank scheduler.
// Inputs change at negedge; outputs sampled 1ns later.
module tb_dc_tagbank_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic        c_req_valid, c_req_retry, c_req_write;
  logic [6:0]  c_req_type, c_req_set;
  logic [23:0] c_req_tag;
  logic [3:0]  c_req_id, c_ack_id;
  logic        c_ack_valid, c_ack_retry, c_ack_hit, c_ack_miss;
  logic [2:0]  c_ack_way;
  logic        c_ack_bank;
  logic        f_req_valid, f_req_retry, f_req_write;
  logic [6:0]  f_req_type, f_req_set;
  logic [23:0] f_req_tag;
  logic [3:0]  f_req_id, f_ack_id;
  logic        f_ack_valid, f_ack_retry, f_ack_hit, f_ack_miss;
  logic [2:0]  f_ack_way;
  logic        f_ack_bank;
  logic        b0_req_valid, b0_req_retry, b0_req_write;
  logic [6:0]  b0_req_type;
  logic [23:0] b0_req_tag;
  logic [5:0]  b0_req_set;
  logic        b0_ack_valid, b0_ack_retry, b0_hit, b0_miss;
  logic [2:0]  b0_way;
  logic [1:0]  b0_occ;
  logic        b1_req_valid, b1_req_retry, b1_req_write;
  logic [6:0]  b1_req_type;
  logic [23:0] b1_req_tag;
  logic [5:0]  b1_req_set;
  logic        b1_ack_valid, b1_ack_retry, b1_hit, b1_miss;
  logic [2:0]  b1_way;
  logic [1:0]  b1_occ;
  logic        sched_err;

  int n_assert = 0;
  int n_fail = 0;

  localparam logic [23:0] CTAG = 24'hAAAAAA;
  localparam logic [23:0] FTAG = 24'h555555;

  always #5 clk = ~clk;

  dc_tagbank_sched dut (
    .clk(clk), .reset(reset),
    .c_req_valid(c_req_valid), .c_req_retry(c_req_retry),
    .c_req_type(c_req_type), .c_req_write(c_req_write),
    .c_req_set(c_req_set), .c_req_tag(c_req_tag),
    .c_req_id(c_req_id), .c_ack_valid(c_ack_valid),
    .c_ack_retry(c_ack_retry), .c_ack_hit(c_ack_hit),
    .c_ack_miss(c_ack_miss), .c_ack_way(c_ack_way),
    .c_ack_id(c_ack_id), .c_ack_bank(c_ack_bank),
    .f_req_valid(f_req_valid), .f_req_retry(f_req_retry),
    .f_req_type(f_req_type), .f_req_write(f_req_write),
    .f_req_set(f_req_set), .f_req_tag(f_req_tag),
    .f_req_id(f_req_id), .f_ack_valid(f_ack_valid),
    .f_ack_retry(f_ack_retry), .f_ack_hit(f_ack_hit),
    .f_ack_miss(f_ack_miss), .f_ack_way(f_ack_way),
    .f_ack_id(f_ack_id), .f_ack_bank(f_ack_bank),
    .b0_req_valid(b0_req_valid), .b0_req_retry(b0_req_retry),
    .b0_req_type(b0_req_type), .b0_req_write(b0_req_write),
    .b0_req_tag(b0_req_tag), .b0_req_set(b0_req_set),
    .b0_ack_valid(b0_ack_valid), .b0_ack_retry(b0_ack_retry),
    .b0_hit(b0_hit), .b0_miss(b0_miss), .b0_way(b0_way),
    .b0_occ(b0_occ),
    .b1_req_valid(b1_req_valid), .b1_req_retry(b1_req_retry),
    .b1_req_type(b1_req_type), .b1_req_write(b1_req_write),
    .b1_req_tag(b1_req_tag), .b1_req_set(b1_req_set),
    .b1_ack_valid(b1_ack_valid), .b1_ack_retry(b1_ack_retry),
    .b1_hit(b1_hit), .b1_miss(b1_miss), .b1_way(b1_way),
    .b1_occ(b1_occ),
    .sched_err(sched_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    c_req_valid = 0; c_req_type = 7'h11; c_req_write = 0;
    c_req_set = 0; c_req_tag = CTAG; c_req_id = 0;
    c_ack_retry = 0;
    f_req_valid = 0; f_req_type = 7'h22; f_req_write = 0;
    f_req_set = 0; f_req_tag = FTAG; f_req_id = 0;
    f_ack_retry = 0;
    b0_req_retry = 0; b0_ack_valid = 0;
    b0_hit = 0; b0_miss = 0; b0_way = 0;
    b1_req_retry = 0; b1_ack_valid = 0;
    b1_hit = 0; b1_miss = 0; b1_way = 0;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic creq(input logic [6:0] s, input logic [3:0] id);
    c_req_valid = 1; c_req_set = s; c_req_id = id;
  endtask

  task automatic freq(input logic [6:0] s, input logic [3:0] id);
    f_req_valid = 1; f_req_set = s; f_req_id = id;
  endtask

  initial begin
    idle();
    reset = 1;
    nxt(); nxt(); settle();
    chk("rst_b0_occ", b0_occ, 0);
    chk("rst_b1_occ", b1_occ, 0);
    chk("rst_c_ack_valid", c_ack_valid, 0);
    chk("rst_f_ack_valid", f_ack_valid, 0);
    chk("rst_b0_req_valid", b0_req_valid, 0);
    chk("rst_c_req_retry", c_req_retry, 0);
    chk("rst_sched_err", sched_err, 0);
    nxt(); reset = 0;

    // Core to bank 0, fill to bank 1 in the same cycle.
    nxt(); creq(7'h04, 4'd3); freq(7'h05, 4'd7); settle();
    chk("dual_b0_valid", b0_req_valid, 1);
    chk("dual_b1_valid", b1_req_valid, 1);
    chk("dual_b0_set", b0_req_set, 6'h02);
    chk("dual_b1_set", b1_req_set, 6'h02);
    chk("dual_b0_tag", b0_req_tag, CTAG);
    chk("dual_b1_tag", b1_req_tag, FTAG);
    chk("dual_c_retry", c_req_retry, 0);
    chk("dual_f_retry", f_req_retry, 0);
    nxt(); idle(); settle();
    chk("dual_b0_occ", b0_occ, 1);
    chk("dual_b1_occ", b1_occ, 1);
    b0_ack_valid = 1; b0_hit = 1; b0_way = 3'd2;
    b1_ack_valid = 1; b1_miss = 1; settle();
    chk("resp_c_valid", c_ack_valid, 1);
    chk("resp_c_id", c_ack_id, 3);
    chk("resp_c_way", c_ack_way, 2);
    chk("resp_c_hit", c_ack_hit, 1);
    chk("resp_c_bank", c_ack_bank, 0);
    chk("resp_f_valid", f_ack_valid, 1);
    chk("resp_f_id", f_ack_id, 7);
    chk("resp_f_miss", f_ack_miss, 1);
    chk("resp_f_bank", f_ack_bank, 1);
    chk("resp_b1_retry", b1_ack_retry, 0);
    nxt(); idle(); settle();
    chk("resp_b0_occ", b0_occ, 0);
    chk("resp_b1_occ", b1_occ, 0);

    // Contention on bank 0: core, fill, core, fill.
    creq(7'h02, 4'd1); freq(7'h06, 4'd9); settle();
    chk("rr1_c_retry", c_req_retry, 0);
    chk("rr1_f_retry", f_req_retry, 1);
    chk("rr1_tag", b0_req_tag, CTAG);
    nxt(); b0_ack_valid = 1; settle();
    chk("rr2_c_retry", c_req_retry, 1);
    chk("rr2_f_retry", f_req_retry, 0);
    chk("rr2_tag", b0_req_tag, FTAG);
    chk("rr2_ack_core", c_ack_valid, 1);
    chk("rr2_ack_id", c_ack_id, 1);
    nxt(); settle();
    chk("rr3_c_retry", c_req_retry, 0);
    chk("rr3_tag", b0_req_tag, CTAG);
    chk("rr3_ack_fill", f_ack_valid, 1);
    chk("rr3_ack_id", f_ack_id, 9);
    chk("rr3_occ", b0_occ, 1);
    nxt(); settle();
    chk("rr4_f_retry", f_req_retry, 0);
    chk("rr4_tag", b0_req_tag, FTAG);
    chk("rr4_ack_core", c_ack_valid, 1);
    nxt(); c_req_valid = 0; f_req_valid = 0; settle();
    chk("rr5_ack_fill", f_ack_valid, 1);
    nxt(); idle(); settle();
    chk("rr_drained", b0_occ, 0);

    // Bank 1 fills up after two lookups.
    creq(7'h03, 4'hA); settle();
    chk("q1_retry", c_req_retry, 0);
    nxt(); creq(7'h03, 4'hB); settle();
    chk("q2_retry", c_req_retry, 0);
    nxt(); creq(7'h03, 4'hC); settle();
    chk("q3_retry", c_req_retry, 1);
    chk("q3_occ", b1_occ, 2);
    chk("q3_bvalid", b1_req_valid, 0);
    nxt(); b1_ack_valid = 1; settle();
    chk("q4_ack", c_ack_valid, 1);
    chk("q4_ack_id", c_ack_id, 4'hA);
    chk("q4_full_block", c_req_retry, 1);
    nxt(); b1_ack_valid = 0; settle();
    chk("q5_occ", b1_occ, 1);
    chk("q5_retry", c_req_retry, 0);
    nxt(); idle(); settle();
    chk("q6_occ", b1_occ, 2);

    // Core heads in both banks answer together.
    creq(7'h00, 4'd5);
    nxt(); idle(); settle();
    chk("cl_b0_occ", b0_occ, 1);
    b0_ack_valid = 1; b0_way = 3'd1;
    b1_ack_valid = 1; b1_way = 3'd4; settle();
    chk("cl_valid", c_ack_valid, 1);
    chk("cl_bank", c_ack_bank, 0);
    chk("cl_way", c_ack_way, 1);
    chk("cl_id", c_ack_id, 5);
    chk("cl_b1_retry", b1_ack_retry, 1);
    chk("cl_b0_retry", b0_ack_retry, 0);
    nxt(); b0_ack_valid = 0; settle();
    chk("cl2_bank", c_ack_bank, 1);
    chk("cl2_way", c_ack_way, 4);
    chk("cl2_id", c_ack_id, 4'hB);
    chk("cl2_b1_retry", b1_ack_retry, 0);
    chk("cl2_b0_occ", b0_occ, 0);
    chk("cl2_b1_occ", b1_occ, 2);
    nxt(); settle();
    chk("cl3_id", c_ack_id, 4'hC);
    nxt(); idle(); settle();
    chk("cl_b1_drained", b1_occ, 0);

    // Core stalls its response for three cycles.
    creq(7'h08, 4'd6);
    nxt(); idle();
    b0_ack_valid = 1; c_ack_retry = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_b0_retry", b0_ack_retry, 1);
      chk("stall_occ", b0_occ, 1);
      nxt();
    end
    c_ack_retry = 0; settle();
    chk("stall_rel_retry", b0_ack_retry, 0);
    chk("stall_rel_valid", c_ack_valid, 1);
    chk("stall_rel_id", c_ack_id, 6);
    nxt(); idle(); settle();
    chk("stall_popped", b0_occ, 0);

    // Orphan response, then reset during traffic.
    b0_ack_valid = 1; settle();
    chk("orph_c_valid", c_ack_valid, 0);
    chk("orph_f_valid", f_ack_valid, 0);
    chk("orph_retry", b0_ack_retry, 0);
    nxt(); idle(); settle();
    chk("orph_err", sched_err, 1);
    creq(7'h02, 4'd2); freq(7'h04, 4'd4); settle();
    chk("pre_rst_c", c_req_retry, 0);
    nxt(); settle();
    chk("pre_rst_f", f_req_retry, 0);
    chk("err_sticky", sched_err, 1);
    #2; reset = 1; idle(); settle();
    chk("mid_rst_occ0", b0_occ, 0);
    chk("mid_rst_err", sched_err, 0);
    chk("mid_rst_bvalid", b0_req_valid, 0);
    chk("mid_rst_cack", c_ack_valid, 0);
    nxt(); reset = 0;
    nxt(); creq(7'h02, 4'd2); freq(7'h04, 4'd4); settle();
    chk("post_rst_rr", c_req_retry, 0);
    chk("post_rst_f", f_req_retry, 1);
    nxt(); idle(); settle();
    chk("post_rst_occ", b0_occ, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
